// File: rtl/ifu.sv
// ifu: instruction fetch unit - PC register, instruction ROM and next-PC select.
// The ROM image is passed in through the IM_INIT parameter. Word 0 sits at byte
// address PC_RESET. The image is built from the hex program image when the
// design is elaborated, so no memory-file load is needed at run time.
// Optional branch delay slot: define IFU_DELAY_SLOT_EN. Without it, a redirect
// takes effect on the same edge and no pending state exists.
module ifu #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024,
   parameter logic [31:0] IM_INIT [IM_WORDS] = '{default: 32'h0000_0000}
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [31:0] ext_off,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic [15:0] imm16,
   output logic        pc_err
);

   localparam int unsigned IDX_W     = $clog2(IM_WORDS);
   localparam logic [32:0] WIN_BYTES = 33'(IM_WORDS) * 33'd4;

   logic [31:0]      pc_r;
   logic [31:0]      off_s;
   logic [IDX_W-1:0] idx_s;
   logic             in_win_s;
   logic [31:0]      rom_word_s;
   logic [31:0]      instr_s;
   logic [31:0]      pc_plus4_s;
   logic [31:0]      tgt_s;
   logic             jr_low_unused_s;

   // window/alignment check against the ROM and the combinational ROM read
   always_comb begin
      off_s      = pc_r - PC_RESET;
      idx_s      = off_s[IDX_W+1:2];
      in_win_s   = (pc_r >= PC_RESET) && ({1'b0, off_s} < WIN_BYTES) && (pc_r[1:0] == 2'b00);
      rom_word_s = IM_INIT[idx_s];
      if (in_win_s) begin
         instr_s = rom_word_s;
      end else begin
         instr_s = 32'h0000_0000;
      end
   end

   // next-PC target from the current pc; all arithmetic wraps mod 2^32
   always_comb begin
      pc_plus4_s = pc_r + 32'd4;
      tgt_s      = pc_plus4_s;
      case (npc_sel)
         2'd0: tgt_s = pc_plus4_s;
         2'd1: begin
            if (br_taken) begin
               tgt_s = pc_plus4_s + ext_off;
            end else begin
               tgt_s = pc_plus4_s;
            end
         end
         2'd2:    tgt_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
         2'd3:    tgt_s = {jr_target[31:2], 2'b00};
         default: tgt_s = pc_plus4_s;
      endcase
   end

`ifdef IFU_DELAY_SLOT_EN
   logic [31:0] pending_tgt_r;
   logic        pending_v_r;
   logic        redirect_s;

   // any selection that leaves the sequential path opens a delay slot
   always_comb begin
      redirect_s = 1'b0;
      case (npc_sel)
         2'd1:       redirect_s = br_taken;
         2'd2, 2'd3: redirect_s = 1'b1;
         default:    redirect_s = 1'b0;
      endcase
   end

   // PC and pending redirect: the slot instruction runs first, then the target is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r          <= PC_RESET;
         pending_tgt_r <= 32'h0000_0000;
         pending_v_r   <= 1'b0;
      end else if (!stall) begin
         if (pending_v_r) begin
            pc_r        <= pending_tgt_r;
            pending_v_r <= 1'b0;
         end else if (redirect_s) begin
            pc_r          <= pc_plus4_s;
            pending_tgt_r <= tgt_s;
            pending_v_r   <= 1'b1;
         end else begin
            pc_r <= pc_plus4_s;
         end
      end else begin
         pc_r          <= pc_r;
         pending_tgt_r <= pending_tgt_r;
         pending_v_r   <= pending_v_r;
      end
   end
`else
   // PC register: a redirect lands on the same edge, stall holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= PC_RESET;
      end else if (!stall) begin
         pc_r <= tgt_s;
      end else begin
         pc_r <= pc_r;
      end
   end
`endif

   // jr targets are forced word-aligned, so the low two register bits carry no meaning
   assign jr_low_unused_s = ^jr_target[1:0];

   assign pc       = pc_r;
   assign pc_plus4 = pc_plus4_s;
   assign instr    = instr_s;
   assign imm16    = instr_s[15:0];
   assign pc_err   = ~in_win_s;

endmodule
